// File: rtl/mult_iter_param_if.sv
// Start/busy/done coprocessor bus for the iterative multiplier.
// The requester drives operands and start; the multiplier returns status and product.
interface mult_iter_param_if #(
  parameter int unsigned WIDTH = 32
);
  logic               start;
  logic               is_signed;
  logic [WIDTH-1:0]   a;
  logic [WIDTH-1:0]   b;
  logic               busy;
  logic               done;
  logic [2*WIDTH-1:0] product;

  modport master (
    output start, is_signed, a, b,
    input  busy, done, product
  );

  modport slave (
    input  start, is_signed, a, b,
    output busy, done, product
  );
endinterface

// File: rtl/mult_iter_param.sv
// Iterative multiplier: accumulates one DIGIT x DIGIT partial product per cycle,
// with optional two's-complement mode, a done pulse and back-to-back issue.
module mult_iter_param #(
  parameter int unsigned WIDTH     = 32,
  parameter int unsigned DIGIT     = 16,
  parameter bit          SIGNED_EN = 1'b1
) (
  input logic              clk,
  input logic              reset,
  mult_iter_param_if.slave bus
);
  localparam int unsigned ND  = WIDTH / DIGIT;
  localparam int unsigned IW  = (ND > 1) ? $clog2(ND) : 1;
  localparam int unsigned PW  = 2 * WIDTH;
  localparam int unsigned DW2 = 2 * DIGIT;

  typedef enum logic [1:0] {IDLE, CALC, FIX, DONE} state_t;

  state_t            state_q, state_d;
  logic [IW-1:0]     i_q, i_d;
  logic [IW-1:0]     j_q, j_d;
  logic [WIDTH-1:0]  amag_q, amag_d;
  logic [WIDTH-1:0]  bmag_q, bmag_d;
  logic              neg_q, neg_d;
  logic [PW-1:0]     prod_q, prod_d;

  logic              eff_signed;
  logic              a_neg, b_neg;
  logic [DIGIT-1:0]  a_dig, b_dig;
  logic [DW2-1:0]    pp;
  logic [31:0]       shamt;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= IDLE;
      i_q     <= '0;
      j_q     <= '0;
      amag_q  <= '0;
      bmag_q  <= '0;
      neg_q   <= 1'b0;
      prod_q  <= '0;
    end else begin
      state_q <= state_d;
      i_q     <= i_d;
      j_q     <= j_d;
      amag_q  <= amag_d;
      bmag_q  <= bmag_d;
      neg_q   <= neg_d;
      prod_q  <= prod_d;
    end
  end

  // The step counter k is kept as separate digit indices (i = k % ND, j = k / ND)
  // so no divider is needed when ND is not a power of two.
  always_comb begin
    state_d    = state_q;
    i_d        = i_q;
    j_d        = j_q;
    amag_d     = amag_q;
    bmag_d     = bmag_q;
    neg_d      = neg_q;
    prod_d     = prod_q;

    eff_signed = bus.is_signed & SIGNED_EN;
    a_neg      = eff_signed & bus.a[WIDTH-1];
    b_neg      = eff_signed & bus.b[WIDTH-1];
    a_dig      = amag_q[32'(i_q)*DIGIT +: DIGIT];
    b_dig      = bmag_q[32'(j_q)*DIGIT +: DIGIT];
    pp         = DW2'(a_dig) * DW2'(b_dig);
    shamt      = (32'(i_q) + 32'(j_q)) * DIGIT;

    unique case (state_q)
      IDLE, DONE: begin
        if (bus.start) begin
          state_d = CALC;
          amag_d  = a_neg ? -bus.a : bus.a;
          bmag_d  = b_neg ? -bus.b : bus.b;
          neg_d   = a_neg ^ b_neg;
          prod_d  = '0;
          i_d     = '0;
          j_d     = '0;
        end else begin
          state_d = IDLE;
        end
      end
      CALC: begin
        prod_d = prod_q + (PW'(pp) << shamt);
        if (32'(i_q) == ND - 1) begin
          i_d = '0;
          if (32'(j_q) == ND - 1) begin
            j_d     = '0;
            state_d = FIX;
          end else begin
            j_d = j_q + 1'b1;
          end
        end else begin
          i_d = i_q + 1'b1;
        end
      end
      FIX: begin
        prod_d  = neg_q ? -prod_q : prod_q;
        state_d = DONE;
      end
      default: state_d = IDLE;
    endcase
  end

  assign bus.busy    = (state_q != IDLE);
  assign bus.done    = (state_q == DONE);
  assign bus.product = prod_q;
endmodule

// File: tb/tb_mult_iter_param.sv
// Directed bench for mult_iter_param: default 32/16 signed unit, a 16/4 unit,
// and a 32/16 unit with signed mode disabled.
module tb_mult_iter_param;
  logic clk;
  logic rst_n;
  int   checks   = 0;
  int   failures = 0;

  mult_iter_param_if #(.WIDTH(32)) bus0();
  mult_iter_param_if #(.WIDTH(16)) bus16();
  mult_iter_param_if #(.WIDTH(32)) busns();

  mult_iter_param #(.WIDTH(32), .DIGIT(16), .SIGNED_EN(1'b1)) u_dut0 (
    .clk(clk), .reset(rst_n), .bus(bus0.slave));
  mult_iter_param #(.WIDTH(16), .DIGIT(4), .SIGNED_EN(1'b1)) u_dut16 (
    .clk(clk), .reset(rst_n), .bus(bus16.slave));
  mult_iter_param #(.WIDTH(32), .DIGIT(16), .SIGNED_EN(1'b0)) u_dutns (
    .clk(clk), .reset(rst_n), .bus(busns.slave));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic drive(input int sel, input logic st, input logic sg,
                       input logic [31:0] a, input logic [31:0] b);
    case (sel)
      0: begin bus0.start = st; bus0.is_signed = sg; bus0.a = a; bus0.b = b; end
      1: begin bus16.start = st; bus16.is_signed = sg; bus16.a = a[15:0]; bus16.b = b[15:0]; end
      default: begin busns.start = st; busns.is_signed = sg; busns.a = a; busns.b = b; end
    endcase
  endtask

  function automatic logic get_done(input int sel);
    case (sel)
      0:       return bus0.done;
      1:       return bus16.done;
      default: return busns.done;
    endcase
  endfunction

  function automatic logic get_busy(input int sel);
    case (sel)
      0:       return bus0.busy;
      1:       return bus16.busy;
      default: return busns.busy;
    endcase
  endfunction

  function automatic logic [63:0] get_prod(input int sel);
    case (sel)
      0:       return bus0.product;
      1:       return 64'(bus16.product);
      default: return busns.product;
    endcase
  endfunction

  // lat = number of rising edges after the accept edge when done is first seen
  task automatic run_op(input int sel, input logic sg, input logic [31:0] a,
                        input logic [31:0] b, output int lat,
                        output logic [63:0] prod, output logic busy_ok);
    @(negedge clk);
    drive(sel, 1'b1, sg, a, b);
    @(posedge clk);
    @(negedge clk);
    drive(sel, 1'b0, 1'b0, a, b);
    lat     = 0;
    busy_ok = get_busy(sel);
    while (!get_done(sel) && lat < 100) begin
      @(negedge clk);
      lat++;
      busy_ok = busy_ok & get_busy(sel);
    end
    prod = get_prod(sel);
  endtask

  int          lat;
  int          ndone;
  logic [63:0] prod;
  logic        bok;

  initial begin
    rst_n = 1'b0;
    drive(0, 1'b0, 1'b0, '0, '0);
    drive(1, 1'b0, 1'b0, '0, '0);
    drive(2, 1'b0, 1'b0, '0, '0);
    repeat (2) @(negedge clk);
    chk("reset_busy",  64'(bus0.busy), 64'd0);
    chk("reset_done",  64'(bus0.done), 64'd0);
    chk("reset_prod",  bus0.product, 64'd0);
    chk("reset_prod16", 64'(bus16.product), 64'd0);
    rst_n = 1'b1;
    @(negedge clk);

    // unsigned full-scale
    run_op(0, 1'b0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, lat, prod, bok);
    chk("u_max_prod", prod, 64'hFFFF_FFFE_0000_0001);
    chk("u_max_lat",  64'(lat), 64'd5);
    chk("u_max_busy", 64'(bok), 64'd1);
    @(negedge clk);
    chk("idle_busy",  64'(bus0.busy), 64'd0);
    chk("idle_done",  64'(bus0.done), 64'd0);
    chk("idle_hold",  bus0.product, 64'hFFFF_FFFE_0000_0001);

    run_op(0, 1'b0, 32'h0, 32'hFFFF_FFFF, lat, prod, bok);
    chk("zero_prod", prod, 64'd0);
    chk("zero_lat",  64'(lat), 64'd5);

    // signed
    run_op(0, 1'b1, 32'hFFFF_FFFD, 32'd5, lat, prod, bok);
    chk("s_m3x5", prod, 64'hFFFF_FFFF_FFFF_FFF1);
    run_op(0, 1'b1, 32'h8000_0000, 32'h8000_0000, lat, prod, bok);
    chk("s_minxmin", prod, 64'h4000_0000_0000_0000);
    run_op(0, 1'b1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, lat, prod, bok);
    chk("s_m1xm1", prod, 64'h1);
    run_op(2, 1'b1, 32'hFFFF_FFFF, 32'd2, lat, prod, bok);
    chk("ns_prod", prod, 64'h1_FFFF_FFFE);

    // start during CALC is ignored
    @(negedge clk);
    drive(0, 1'b1, 1'b0, 32'd7, 32'd6);
    @(posedge clk);
    @(negedge clk);
    drive(0, 1'b1, 1'b0, 32'd9, 32'd9);
    ndone = 0;
    prod  = '0;
    for (int n = 1; n <= 12; n++) begin
      @(negedge clk);
      if (n == 3) drive(0, 1'b0, 1'b0, 32'd9, 32'd9);
      if (bus0.done) begin
        ndone++;
        prod = bus0.product;
      end
    end
    chk("calc_start_ndone", 64'(ndone), 64'd1);
    chk("calc_start_prod",  prod, 64'd42);

    // back-to-back issue from DONE
    run_op(0, 1'b0, 32'd7, 32'd6, lat, prod, bok);
    chk("b2b_first_prod", prod, 64'd42);
    chk("b2b_first_done", 64'(bus0.done), 64'd1);
    drive(0, 1'b1, 1'b0, 32'd3, 32'd4);
    @(posedge clk);
    @(negedge clk);
    drive(0, 1'b0, 1'b0, 32'd3, 32'd4);
    chk("b2b_clear_prod", bus0.product, 64'd0);
    chk("b2b_clear_busy", 64'(bus0.busy), 64'd1);
    chk("b2b_clear_done", 64'(bus0.done), 64'd0);
    lat = 0;
    bok = bus0.busy;
    while (!bus0.done && lat < 100) begin
      @(negedge clk);
      lat++;
      bok = bok & bus0.busy;
    end
    chk("b2b_second_lat",  64'(lat), 64'd5);
    chk("b2b_second_prod", bus0.product, 64'd12);
    chk("b2b_busy_held",   64'(bok), 64'd1);

    // reset mid-operation
    @(negedge clk);
    drive(0, 1'b1, 1'b0, 32'd3, 32'd5);
    @(posedge clk);
    @(negedge clk);
    drive(0, 1'b0, 1'b0, 32'd3, 32'd5);
    @(posedge clk);
    @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    chk("abort_busy", 64'(bus0.busy), 64'd0);
    chk("abort_done", 64'(bus0.done), 64'd0);
    chk("abort_prod", bus0.product, 64'd0);
    @(negedge clk);
    rst_n = 1'b1;
    ndone = 0;
    for (int n = 0; n < 8; n++) begin
      @(negedge clk);
      if (bus0.done) ndone++;
    end
    chk("abort_no_done", 64'(ndone), 64'd0);
    run_op(0, 1'b0, 32'h1234_5678, 32'h9ABC_DEF0, lat, prod, bok);
    chk("restart_prod", prod, 64'h0B00_EA4E_242D_2080);
    chk("restart_lat",  64'(lat), 64'd5);

    // 16-bit operands with 4-bit digits
    run_op(1, 1'b0, 32'h0000_FFFF, 32'h0000_FFFF, lat, prod, bok);
    chk("w16_u_prod", prod, 64'hFFFE_0001);
    chk("w16_u_lat",  64'(lat), 64'd17);
    chk("w16_u_busy", 64'(bok), 64'd1);
    run_op(1, 1'b1, 32'h0000_8000, 32'h0000_7FFF, lat, prod, bok);
    chk("w16_s_prod", prod, 64'hC000_8000);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
